// File: rtl/control_unit.sv
// Moore controller for a small load/store CPU. It sequences fetch, decode and
// execute, and decodes its datapath controls from the state register and IR.
module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IR,
  output logic        PC_clr,
  output logic        PC_up,
  output logic        IR_ld,
  output logic [7:0]  D_addr,
  output logic        D_wr,
  output logic        RF_s,
  output logic [3:0]  RF_W_addr,
  output logic        RF_W_en,
  output logic [3:0]  RF_Ra_addr,
  output logic [3:0]  RF_Rb_addr,
  output logic [2:0]  ALU_s0,
  output logic        halted,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t cur;

  // State register; reset has priority over every transition, including HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= S_INIT;
    end else begin
      case (cur)
        S_INIT:   cur <= S_FETCH;
        S_FETCH:  cur <= S_DECODE;
        S_DECODE: begin
          case (IR[15:12])
            4'h0:    cur <= S_NOOP;
            4'h1:    cur <= S_STORE;
            4'h2:    cur <= S_LOAD_A;
            4'h3:    cur <= S_ADD;
            4'h4:    cur <= S_SUB;
            4'h5:    cur <= S_HALT;
            default: cur <= S_NOOP;
          endcase
        end
        S_LOAD_A: cur <= S_LOAD_B;
        S_NOOP,
        S_LOAD_B,
        S_STORE,
        S_ADD,
        S_SUB:    cur <= S_FETCH;
        S_HALT:   cur <= S_HALT;
        default:  cur <= S_INIT;
      endcase
    end
  end

  // Output decode from the registered state and the held instruction only.
  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IR_ld      = 1'b0;
    D_addr     = 8'h00;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = 4'h0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = 4'h0;
    RF_Rb_addr = 4'h0;
    ALU_s0     = 3'd0;
    halted     = 1'b0;
    case (cur)
      S_INIT: PC_clr = 1'b1;
      S_FETCH: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
      end
      // LOAD_A only presents the address, covering the synchronous read latency.
      S_LOAD_A: begin
        D_addr = IR[7:0];
        RF_s   = 1'b1;
      end
      S_LOAD_B: begin
        D_addr    = IR[7:0];
        RF_s      = 1'b1;
        RF_W_addr = IR[11:8];
        RF_W_en   = 1'b1;
      end
      S_STORE: begin
        D_addr     = IR[7:0];
        RF_Ra_addr = IR[11:8];
        D_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = IR[11:8];
        RF_Rb_addr = IR[7:4];
        RF_W_addr  = IR[3:0];
        RF_W_en    = 1'b1;
        ALU_s0     = (cur == S_ADD) ? 3'd1 : 3'd2;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign state = cur;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus random
// instruction streams checked against an instruction-level reference model.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] IR;
  logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en, halted;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, state;
  logic [2:0]  ALU_s0;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic       pc_clr;
    logic       pc_up;
    logic       ir_ld;
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] w_addr;
    logic       w_en;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
    logic       halted;
    logic [3:0] st;
  } obs_t;

  control_unit dut (
    .clk(clk), .reset(reset), .IR(IR),
    .PC_clr(PC_clr), .PC_up(PC_up), .IR_ld(IR_ld),
    .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
    .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
    .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
    .ALU_s0(ALU_s0), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  function automatic obs_t init_vec();
    obs_t e;
    e = '0;
    e.pc_clr = 1'b1;
    e.st = 4'd0;
    return e;
  endfunction

  function automatic obs_t halt_vec();
    obs_t e;
    e = '0;
    e.halted = 1'b1;
    e.st = 4'd9;
    return e;
  endfunction

  // Cycles from one FETCH to the next for a given instruction.
  function automatic int instr_len(logic [15:0] ir);
    return (ir[15:12] == 4'h2) ? 4 : 3;
  endfunction

  // Expected controls in cycle k of an instruction (k=0 is FETCH).
  function automatic obs_t expect_at(logic [15:0] ir, int k);
    obs_t e;
    logic [3:0] op;
    e = '0;
    op = ir[15:12];
    if (k == 0) begin
      e.pc_up = 1'b1; e.ir_ld = 1'b1; e.st = 4'd1;
    end else if (k == 1) begin
      e.st = 4'd2;
    end else if (k == 2) begin
      case (op)
        4'h1: begin e.st = 4'd6; e.d_addr = ir[7:0]; e.ra = ir[11:8]; e.d_wr = 1'b1; end
        4'h2: begin e.st = 4'd4; e.d_addr = ir[7:0]; e.rf_s = 1'b1; end
        4'h3, 4'h4: begin
          e.st = (op == 4'h3) ? 4'd7 : 4'd8;
          e.ra = ir[11:8]; e.rb = ir[7:4]; e.w_addr = ir[3:0]; e.w_en = 1'b1;
          e.alu = (op == 4'h3) ? 3'd1 : 3'd2;
        end
        4'h5: e = halt_vec();
        default: e.st = 4'd3;
      endcase
    end else begin
      e.st = 4'd5; e.d_addr = ir[7:0]; e.rf_s = 1'b1; e.w_addr = ir[11:8]; e.w_en = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string tag, input obs_t e);
    obs_t o;
    o = {PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
         RF_Ra_addr, RF_Rb_addr, ALU_s0, halted, state};
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Entered at negedge while in FETCH; leaves at the next FETCH.
  task automatic run_instr(input string tag, input logic [15:0] ir);
    IR = ir;
    #1;
    for (int k = 0; k < instr_len(ir); k++) begin
      check(tag, expect_at(ir, k));
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] ir;
    reset = 1'b1;
    IR = 16'h0000;

    @(negedge clk); #1;
    check("reset_hold0", init_vec());
    @(negedge clk); #1;
    check("reset_hold1", init_vec());
    reset = 1'b0;
    @(negedge clk); #1;

    run_instr("load_2A1F", 16'h2A1F);
    run_instr("add_3123", 16'h3123);
    run_instr("sub_4123", 16'h4123);
    run_instr("store_1305", 16'h1305);
    run_instr("noop_F000", 16'hF000);
    run_instr("noop_0000", 16'h0000);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'h5) op = 4'h2;
      ir = {op, 12'($urandom)};
      run_instr($sformatf("rand_%0d_%h", i, ir), ir);
    end

    // Reset in the middle of a load must abandon it before the write.
    ir = {4'h2, 12'($urandom)};
    IR = ir;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("load_abort", expect_at(ir, k));
      @(negedge clk); #1;
      if (k == 1) reset = 1'b1;
    end
    check("load_abort_init", init_vec());
    compared++;
    assert (RF_W_en === 1'b0) else begin
      mismatched++;
      $error("FAIL load_abort_wen observed=%b expected=0", RF_W_en);
    end
    reset = 1'b0;
    @(negedge clk); #1;
    run_instr("after_abort_add", {4'h3, 12'($urandom)});

    IR = 16'h5000;
    #1;
    check("halt_fetch", expect_at(16'h5000, 0));
    @(negedge clk); #1;
    check("halt_decode", expect_at(16'h5000, 1));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      check($sformatf("halt_hold_%0d", i), halt_vec());
      IR = 16'($urandom);
    end
    reset = 1'b1;
    @(negedge clk); #1;
    check("halt_reset", init_vec());
    reset = 1'b0;
    @(negedge clk); #1;
    run_instr("post_halt_store", {4'h1, 12'($urandom)});
    run_instr("post_halt_load", {4'h2, 12'($urandom)});
    check("final_fetch", expect_at(16'h0000, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
